cpu_state_dumper: RTL

Debug readout engine that sits beside the single-cycle CPU on the board top. It drives the CPU's display-read ports (`rf_addr`, `mem_addr`) and reads back `rf_data` and `mem_data`. On each `start` pulse it snapshots PC and instruction, holds the CPU, and walks all 32 registers and a window of data RAM. It streams the result as a framed byte sequence over a valid/ready byte interface to the board's UART transmitter.

---
 rtl/dbg_pkg.sv | 27 ++
 rtl/word_byte_shifter.sv | 46 ++++
 rtl/cpu_state_dumper.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/dbg_pkg.sv
// ============================================================================
// Module      : dbg_pkg
// Description : Shared types and constants for the CPU state dump engine.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dbg_pkg;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_HDR   = 4'd1,
        ST_SNAP  = 4'd2,
        ST_RSET  = 4'd3,
        ST_RSEND = 4'd4,
        ST_MSET  = 4'd5,
        ST_MSEND = 4'd6,
        ST_CSUM  = 4'd7,
        ST_DONE  = 4'd8
    } dbg_state_e;

    localparam logic [7:0] DBG_HDR  = 8'hA5;
    localparam int         DBG_NREG = 32;

endpackage

`default_nettype wire

// File: rtl/word_byte_shifter.sv
// ============================================================================
// Module      : word_byte_shifter
// Description : Loads a 32-bit word and emits it as 4 bytes, MSB first.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module word_byte_shifter (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_i,
    input  logic [31:0] word_i,
    input  logic        ready_i,
    output logic        valid_o,
    output logic [7:0]  byte_o,
    output logic        last_o
);

    logic [31:0] word_q;
    logic [1:0]  idx_q;
    logic        valid_q;

    // A load wins over a shift so the next word can follow the last byte back-to-back.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_q  <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
        end else if (load_i) begin
            word_q  <= word_i;
            idx_q   <= '0;
            valid_q <= 1'b1;
        end else if (valid_q && ready_i) begin
            word_q  <= {word_q[23:0], 8'h00};
            idx_q   <= idx_q + 2'd1;
            valid_q <= (idx_q != 2'd3);
        end
    end

    assign valid_o = valid_q;
    assign byte_o  = word_q[31:24];
    assign last_o  = (idx_q == 2'd3);

endmodule

`default_nettype wire

// File: rtl/cpu_state_dumper.sv
// ============================================================================
// Module      : cpu_state_dumper
// Description : Snapshots PC/inst, walks registers and a RAM window, and
//               streams a checksummed byte frame to a UART transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cpu_state_dumper
    import dbg_pkg::*;
#(
    parameter int          MEM_WORDS = 32,
    parameter logic [31:0] MEM_BASE  = 32'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] cpu_pc,
    input  logic [31:0] cpu_inst,
    output logic [4:0]  rf_addr,
    input  logic [31:0] rf_data,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_data,
    output logic        cpu_hold,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        busy,
    output logic        done
);

    localparam logic [5:0] c_LAST_REG = 6'(DBG_NREG - 1);
    localparam logic [5:0] c_LAST_MEM = 6'(MEM_WORDS - 1);

    dbg_state_e  state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [7:0]  csum_q, csum_d;
    logic [31:0] inst_q, inst_d;

    logic        sh_load, sh_ready, sh_valid, sh_last;
    logic [31:0] sh_word;
    logic [7:0]  sh_byte;
    logic        byte_state, byte_xfer;

    assign byte_state = (state_q == ST_SNAP) || (state_q == ST_RSEND) || (state_q == ST_MSEND);
    assign sh_ready   = tx_ready && byte_state;
    assign byte_xfer  = sh_ready && sh_valid;

    word_byte_shifter u_shifter (
        .clk     (clk),
        .rst     (reset),
        .load_i  (sh_load),
        .word_i  (sh_word),
        .ready_i (sh_ready),
        .valid_o (sh_valid),
        .byte_o  (sh_byte),
        .last_o  (sh_last)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            csum_q  <= '0;
            inst_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            csum_q  <= csum_d;
            inst_q  <= inst_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        csum_d  = byte_xfer ? (csum_q ^ sh_byte) : csum_q;
        inst_d  = inst_q;
        sh_load = 1'b0;
        sh_word = cpu_pc;
        done    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_HDR;
                    cnt_d   = '0;
                    csum_d  = '0;
                    inst_d  = cpu_inst;
                    sh_load = 1'b1;
                    sh_word = cpu_pc;
                end
            end
            ST_HDR: begin
                if (tx_ready) state_d = ST_SNAP;
            end
            // cnt 0 is the PC word, cnt 1 the instruction word.
            ST_SNAP: begin
                if (byte_xfer && sh_last) begin
                    if (cnt_q == 6'd0) begin
                        cnt_d   = 6'd1;
                        sh_load = 1'b1;
                        sh_word = inst_q;
                    end else begin
                        cnt_d   = '0;
                        state_d = ST_RSET;
                    end
                end
            end
            ST_RSET: begin
                sh_load = 1'b1;
                sh_word = rf_data;
                state_d = ST_RSEND;
            end
            ST_RSEND: begin
                if (byte_xfer && sh_last) begin
                    if (cnt_q == c_LAST_REG) begin
                        cnt_d   = '0;
                        state_d = ST_MSET;
                    end else begin
                        cnt_d   = cnt_q + 6'd1;
                        state_d = ST_RSET;
                    end
                end
            end
            ST_MSET: begin
                sh_load = 1'b1;
                sh_word = mem_data;
                state_d = ST_MSEND;
            end
            ST_MSEND: begin
                if (byte_xfer && sh_last) begin
                    if (cnt_q == c_LAST_MEM) begin
                        cnt_d   = '0;
                        state_d = ST_CSUM;
                    end else begin
                        cnt_d   = cnt_q + 6'd1;
                        state_d = ST_MSET;
                    end
                end
            end
            ST_CSUM: begin
                if (tx_ready) state_d = ST_DONE;
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        unique case (state_q)
            ST_HDR: begin
                tx_valid = 1'b1;
                tx_data  = DBG_HDR;
            end
            ST_CSUM: begin
                tx_valid = 1'b1;
                tx_data  = csum_q;
            end
            ST_SNAP, ST_RSEND, ST_MSEND: begin
                tx_valid = sh_valid;
                tx_data  = sh_byte;
            end
            default: begin
                tx_valid = 1'b0;
                tx_data  = 8'h00;
            end
        endcase
    end

    // The DONE cycle already releases the CPU, so busy spans HDR..CSUM only.
    assign busy     = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign cpu_hold = busy;

    assign rf_addr  = ((state_q == ST_RSET) || (state_q == ST_RSEND)) ? cnt_q[4:0] : 5'd0;
    assign mem_addr = ((state_q == ST_MSET) || (state_q == ST_MSEND))
                    ? (MEM_BASE + {24'd0, cnt_q, 2'b00}) : MEM_BASE;

endmodule

`default_nettype wire
